// File: rtl/pdm_deserializer.sv
// pdm_deserializer: PDM microphone front end.
//   Divides the system clock to make the microphone clock, samples one or two interleaved PDM
//   channels through a 2-flop synchroniser, packs WIDTH-bit words (first bit received = MSB)
//   and queues them in a first-word-fall-through FIFO with a valid/ready output side.
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   enable                run capture; low stops pdm_clk_o and drops any partial word
//   data_in               asynchronous PDM data from the microphone
//   pdm_clk_o             registered microphone clock
//   pdm_lrsel_o           channel select, tied low
//   word_data, word_chan  FIFO head word and its channel (0 when empty)
//   word_valid            FIFO not empty
//   word_ready            consumer accepts the head word
//   overflow              sticky: a completed word was dropped on a full FIFO
//   clear_overflow        synchronous clear of overflow (a new drop wins)
module pdm_deserializer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CLK_DIV    = 100,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STEREO     = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             data_in,
  output logic             pdm_clk_o,
  output logic             pdm_lrsel_o,
  output logic [WIDTH-1:0] word_data,
  output logic             word_chan,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             clear_overflow
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf  = DivW'(CLK_DIV / 2);
  localparam logic [DivW-1:0] HalfLast = DivW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(WIDTH - 1);
  localparam logic [OccW-1:0] OccFull  = OccW'(FIFO_DEPTH);

  // Synchroniser and divider
  logic            r_sync1;
  logic            r_sync2;
  logic            r_running;
  logic [DivW-1:0] r_div_cnt;
  logic            r_pdm_clk;

  // Per-channel word assembly
  logic [1:0][WIDTH-1:0] r_shift;
  logic [1:0][CntW-1:0]  r_bit_cnt;

  // Output FIFO, entry = {chan, data}
  logic [WIDTH:0]  r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [OccW-1:0] r_count;
  logic            r_overflow;

  logic            w_counting;
  logic [DivW-1:0] w_div_next;
  logic            w_pdm_clk_next;
  logic [1:0]      w_sample;
  logic            w_push;
  logic            w_push_chan;
  logic [WIDTH-1:0] w_push_data;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push_acc;
  logic            w_drop;
  logic [OccW-1:0] w_count_next;
  logic [WIDTH:0]  w_head;

  // The divider only advances once running has caught up with enable, so the first cycle after
  // enable rises sits at div_cnt = 0, and a falling enable forces 0 on the very next edge.
  always_comb begin
    w_counting     = enable && r_running;
    w_div_next     = '0;
    if (w_counting) begin
      w_div_next = (r_div_cnt == DivLast) ? '0 : r_div_cnt + DivW'(1);
    end
    // Derived from the next count so the clock flop changes on the same edge as div_cnt.
    w_pdm_clk_next = enable && (w_div_next < DivHalf);
  end

  // Channel 0 sampled at the end of the high phase, channel 1 at the end of the low phase.
  always_comb begin
    w_sample[0] = w_counting && (r_div_cnt == HalfLast);
    w_sample[1] = (STEREO != 0) && w_counting && (r_div_cnt == DivLast);
    w_push      = (w_sample[0] && (r_bit_cnt[0] == BitLast)) ||
                  (w_sample[1] && (r_bit_cnt[1] == BitLast));
    // The two sample points never coincide, so the channel is whichever one sampled.
    w_push_chan = w_sample[1];
    w_push_data = w_sample[1] ? {r_shift[1][WIDTH-2:0], r_sync2}
                              : {r_shift[0][WIDTH-2:0], r_sync2};
  end

  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == OccFull);
    w_pop      = !w_empty && word_ready;
    // A push into a full FIFO still lands if the head leaves on the same edge.
    w_push_acc = w_push && (!w_full || w_pop);
    w_drop     = w_push && w_full && !w_pop;
    unique case ({w_push_acc, w_pop})
      2'b10:   w_count_next = r_count + OccW'(1);
      2'b01:   w_count_next = r_count - OccW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_running  <= 1'b0;
      r_div_cnt  <= '0;
      r_pdm_clk  <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sync1   <= data_in;
      r_sync2   <= r_sync1;
      r_running <= enable;
      r_div_cnt <= w_div_next;
      r_pdm_clk <= w_pdm_clk_next;

      for (int c = 0; c < 2; c++) begin
        if (!enable) begin
          r_shift[c]   <= '0;
          r_bit_cnt[c] <= '0;
        end else if (w_sample[c]) begin
          r_shift[c]   <= {r_shift[c][WIDTH-2:0], r_sync2};
          r_bit_cnt[c] <= (r_bit_cnt[c] == BitLast) ? '0 : r_bit_cnt[c] + CntW'(1);
        end
      end

      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= w_count_next;

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= {w_push_chan, w_push_data};
    end
  end

  always_comb begin
    w_head = r_mem[r_rd_ptr];
  end

  assign pdm_clk_o   = r_pdm_clk;
  assign pdm_lrsel_o = 1'b0;
  assign word_valid  = !w_empty;
  assign word_data   = w_empty ? '0 : w_head[WIDTH-1:0];
  assign word_chan   = !w_empty && w_head[WIDTH];
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_pdm_deserializer.sv
// Bench for pdm_deserializer: a mono and a stereo instance share clock, reset, enable and data.
// A reference model built from bit lists and word queues predicts every cycle's outputs.
module tb_pdm_deserializer;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned HALF    = CLK_DIV / 2;

  logic             clock     = 1'b0;
  logic             reset_n   = 1'b0;
  logic             enable    = 1'b0;
  logic             data_in   = 1'b0;
  logic             clear_ovf = 1'b0;
  logic [1:0]       ready     = 2'b00;
  logic [1:0]       pdm_clk;
  logic [1:0]       lrsel;
  logic [1:0]       wchan;
  logic [1:0]       wvalid;
  logic [1:0]       ovf;
  logic [1:0][WIDTH-1:0] wdata;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  pdm_deserializer #(
    .WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .STEREO(0)
  ) u_mono (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(data_in),
    .pdm_clk_o(pdm_clk[0]), .pdm_lrsel_o(lrsel[0]), .word_data(wdata[0]),
    .word_chan(wchan[0]), .word_valid(wvalid[0]), .word_ready(ready[0]),
    .overflow(ovf[0]), .clear_overflow(clear_ovf)
  );

  pdm_deserializer #(
    .WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .STEREO(1)
  ) u_stereo (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(data_in),
    .pdm_clk_o(pdm_clk[1]), .pdm_lrsel_o(lrsel[1]), .word_data(wdata[1]),
    .word_chan(wchan[1]), .word_valid(wvalid[1]), .word_ready(ready[1]),
    .overflow(ovf[1]), .clear_overflow(clear_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              hist0, hist1;       // data_in at the previous edge / two edges back
  bit              m_run;
  int unsigned     m_t;                // cycles since running started
  bit              bq [2][2][$];       // [dut][chan] bits collected for the word in progress
  logic [WIDTH:0]  mq [2][$];          // [dut] queued {chan, data}
  bit              m_ovf [2];
  logic [WIDTH-1:0] tx_q [2][$];       // words to transmit per channel slot
  logic [WIDTH:0]  popped [2][$];      // words the DUT handed over

  always @(posedge clock or negedge reset_n) begin
    int unsigned    ph;
    bit             b;
    bit             do_pop;
    bit             do_push;
    bit             dropped;
    logic [WIDTH:0] w;
    if (!reset_n) begin
      hist0 = 1'b0;
      hist1 = 1'b0;
      m_run = 1'b0;
      m_t   = 0;
      for (int d = 0; d < 2; d++) begin
        bq[d][0].delete();
        bq[d][1].delete();
        mq[d].delete();
        m_ovf[d] = 1'b0;
      end
    end else begin
      b  = hist1;
      ph = m_t % CLK_DIV;
      for (int d = 0; d < 2; d++) begin
        do_push = 1'b0;
        dropped = 1'b0;
        w       = '0;
        do_pop  = (mq[d].size() != 0) && ready[d];
        if (!enable) begin
          bq[d][0].delete();
          bq[d][1].delete();
        end else if (m_run) begin
          for (int c = 0; c < 2; c++) begin
            if ((c == 0 && ph == HALF - 1) || (c == 1 && d == 1 && ph == CLK_DIV - 1)) begin
              bq[d][c].push_back(b);
              if (bq[d][c].size() == WIDTH) begin
                w[WIDTH] = (c == 1);
                for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = bq[d][c][i];
                bq[d][c].delete();
                do_push = 1'b1;
                if (d == 1 && tx_q[c].size() != 0) void'(tx_q[c].pop_front());
              end
            end
          end
        end
        if (do_pop) void'(mq[d].pop_front());
        if (do_push) begin
          if (mq[d].size() < DEPTH) mq[d].push_back(w);
          else dropped = 1'b1;
        end
        if (dropped) m_ovf[d] = 1'b1;
        else if (clear_ovf) m_ovf[d] = 1'b0;
      end
      m_t   = (m_run && enable) ? m_t + 1 : 0;
      m_run = enable;
      hist1 = hist0;
      hist0 = data_in;
    end
  end

  // Data driver: first half of each PDM period carries channel 0, second half channel 1.
  always @(negedge clock) begin
    int             ch;
    int unsigned    nb;
    logic [WIDTH-1:0] w;
    ch = ((m_t % CLK_DIV) < HALF) ? 0 : 1;
    if (tx_q[ch].size() != 0) begin
      w  = tx_q[ch][0];
      nb = bq[1][ch].size();
      data_in = w[WIDTH-1-nb];
    end else begin
      data_in = 1'($urandom);
    end
  end

  // Every-cycle comparison against the model, plus pop capture.
  always @(negedge clock) begin
    logic [WIDTH:0] h;
    logic [19:0]    exp_v;
    logic [19:0]    got_v;
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        h = (mq[d].size() != 0) ? mq[d][0] : '0;
        exp_v = {mq[d].size() != 0, h[WIDTH], h[WIDTH-1:0], m_ovf[d],
                 m_run && ((m_t % CLK_DIV) < HALF)};
        got_v = {wvalid[d], wchan[d], wdata[d], ovf[d], pdm_clk[d]};
        check_eq($sformatf("cycle_dut%0d{valid,chan,data,ovf,pdmclk}", d), got_v, exp_v);
        if (wvalid[d] && ready[d]) popped[d].push_back({wchan[d], wdata[d]});
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic drain();
    enable    = 1'b0;
    ready     = 2'b11;
    clear_ovf = 1'b1;
    repeat (12) step();
    ready     = 2'b00;
    clear_ovf = 1'b0;
    step();
    tx_q[0].delete();
    tx_q[1].delete();
    popped[0].delete();
    popped[1].delete();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!wvalid[0] && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq({tag, "_valid"}, wvalid[d], 1'b0);
      check_eq({tag, "_data"}, wdata[d], '0);
      check_eq({tag, "_chan"}, wchan[d], 1'b0);
      check_eq({tag, "_ovf"}, ovf[d], 1'b0);
      check_eq({tag, "_pdmclk"}, pdm_clk[d], 1'b0);
      check_eq({tag, "_lrsel"}, lrsel[d], 1'b0);
    end
  endtask

  initial begin
    int             c;
    int             n;
    logic [7:0]     pat;
    logic [WIDTH:0] v;
    logic [WIDTH-1:0] exp_words [4];

    #3;
    check_reset_outputs("reset");
    step();
    step();
    reset_n = 1'b1;
    step();

    // Mono word latency and PDM clock shape.
    tx_q[0].push_back(16'hA5C3);
    enable = 1'b1;
    step();
    c   = 1;
    pat = '0;
    while (c < 300) begin
      if (c <= 8) pat = {pat[6:0], pdm_clk[0]};
      if (wvalid[0]) break;
      step();
      c++;
    end
    check_eq("pdmclk_shape", pat, 8'hF0);
    check_eq("mono_valid_cycle", c, 125);
    check_eq("mono_data", wdata[0], 16'hA5C3);
    check_eq("mono_chan", wchan[0], 1'b0);
    check_eq("stereo_ch0_head", {wchan[1], wdata[1]}, {1'b0, 16'hA5C3});

    // Stereo interleaving.
    drain();
    tx_q[0].push_back(16'h1234);
    tx_q[1].push_back(16'hFEDC);
    ready[1] = 1'b1;
    enable   = 1'b1;
    n = 0;
    while (popped[1].size() < 2 && n < 400) begin
      step();
      n++;
    end
    check_eq("stereo_count", popped[1].size() >= 2, 1'b1);
    v = (popped[1].size() > 0) ? popped[1][0] : '1;
    check_eq("stereo_word0", v, {1'b0, 16'h1234});
    v = (popped[1].size() > 1) ? popped[1][1] : '1;
    check_eq("stereo_word1", v, {1'b1, 16'hFEDC});
    check_eq("mono_ch0_only", {wchan[0], wdata[0]}, {1'b0, 16'h1234});

    // Overflow with a full FIFO, clear, then push and pop on the same edge.
    drain();
    tx_q[0] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    enable  = 1'b1;
    n = 0;
    while (tx_q[0].size() > 1 && n < 900) begin
      step();
      n++;
    end
    check_eq("ovf_set", ovf[0], 1'b1);
    check_eq("ovf_head_kept", wdata[0], 16'h1111);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check_eq("ovf_cleared", ovf[0], 1'b0);
    repeat (3) step();
    check_eq("ovf_stays_clear", ovf[0], 1'b0);
    n = 0;
    while (!(bq[0][0].size() == WIDTH - 1 && (m_t % CLK_DIV) == HALF - 1) && n < 300) begin
      step();
      n++;
    end
    ready[0] = 1'b1;
    step();
    ready[0] = 1'b0;
    check_eq("pushpop_ovf", ovf[0], 1'b0);
    check_eq("pushpop_head", wdata[0], 16'h2222);
    v = (popped[0].size() > 0) ? popped[0][0] : '1;
    check_eq("pushpop_popped", v, {1'b0, 16'h1111});
    popped[0].delete();
    enable   = 1'b0;
    ready[0] = 1'b1;
    repeat (8) step();
    ready[0] = 1'b0;
    exp_words = '{16'h2222, 16'h3333, 16'h4444, 16'h6666};
    check_eq("full_drain_count", popped[0].size(), 4);
    for (int i = 0; i < 4; i++) begin
      v = (popped[0].size() > i) ? popped[0][i] : '1;
      check_eq($sformatf("full_drain_word%0d", i), v, {1'b0, exp_words[i]});
    end
    check_eq("full_drain_empty", wvalid[0], 1'b0);

    // Enable dropped after 7 bits, then a clean word.
    drain();
    tx_q[0].push_back(16'hBEEF);
    enable = 1'b1;
    n = 0;
    while (bq[1][0].size() != 7 && n < 200) begin
      step();
      n++;
    end
    enable = 1'b0;
    step();
    check_eq("drop_pdmclk_mono", pdm_clk[0], 1'b0);
    check_eq("drop_pdmclk_stereo", pdm_clk[1], 1'b0);
    repeat (30) step();
    check_eq("drop_no_push", wvalid[0], 1'b0);
    tx_q[0].delete();
    tx_q[0].push_back(16'h00FF);
    enable = 1'b1;
    wait_valid(200);
    check_eq("reenable_data", {wvalid[0], wdata[0]}, {1'b1, 16'h00FF});

    // Asynchronous reset mid-word with two words queued.
    drain();
    tx_q[0] = '{16'h0101, 16'h0202};
    enable  = 1'b1;
    n = 0;
    while (!(mq[0].size() == 2 && bq[0][0].size() >= 5) && n < 600) begin
      step();
      n++;
    end
    check_eq("pre_reset_valid", wvalid[0], 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    step();
    tx_q[0].delete();
    tx_q[1].delete();
    tx_q[0].push_back(16'hC0DE);
    reset_n = 1'b1;
    wait_valid(200);
    check_eq("post_reset_word", {wvalid[0], wchan[0], wdata[0]}, {2'b10, 16'hC0DE});

    enable = 1'b0;
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdm_deserializer.md
# pdm_deserializer

Parametrised PDM microphone front end: generates the microphone clock by dividing the system clock, samples one or two interleaved PDM channels, and assembles WIDTH-bit words (first bit received ends up as MSB). Completed words go into a small first-word-fall-through FIFO with a valid/ready output handshake. Overflow is flagged with a sticky bit. It sits between the board microphone pins and the sample-storage / memory-write logic.

## Interface
- WIDTH, 16: bits per output word; must be ≥ 2.
- CLK_DIV, 100: system clocks per PDM clock period; even and ≥ 8.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥ 2.
- STEREO, 0: 0 = mono (channel 0 only), 1 = two channels interleaved on one data line.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run capture; low stops the PDM clock and discards any partial word.
- data_in  in  1  PDM data from the microphone; asynchronous, passed through a 2-flop synchroniser.
- pdm_clk_o  out  1  microphone clock, driven from a flop.
- pdm_lrsel_o  out  1  channel select; constant 0.
- word_data  out  WIDTH  FIFO head word; 0 when the FIFO is empty.
- word_chan  out  1  channel of the head word; 0 when empty.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the head word.
- overflow  out  1  sticky: a completed word was dropped.
- clear_overflow  in  1  synchronous clear of overflow.

## Operation
- Reset (asynchronous):
  - div_cnt = 0, running = 0, shift registers and bit counters = 0, FIFO empty.
  - pdm_clk_o = 0, word_valid = 0, word_data = 0, word_chan = 0, overflow = 0.
- Divider:
  - running is a register that follows enable (one-cycle delay).
  - While running, div_cnt counts 0 … CLK_DIV−1 and wraps to 0.
  - pdm_clk_o = 1 for div_cnt in [0, CLK_DIV/2−1], otherwise 0. It is registered so that it changes on the same edge as div_cnt.
  - While not running: div_cnt = 0, pdm_clk_o = 0.
- Sample points, using the synchronised data:
  - Channel 0 is sampled in the cycle where div_cnt = CLK_DIV/2−1 (last cycle of the high phase).
  - Channel 1 is sampled where div_cnt = CLK_DIV−1, and only when STEREO = 1.
- Per-channel shift register: shift left, new bit into LSB; bit counter 0 … WIDTH−1.
- Word completion: on the sample edge that captures bit WIDTH−1, the whole word {chan, shift value including the new bit} is pushed, and that channel's counter returns to 0.
- Only one channel can complete in a given cycle, so there is at most one push per cycle.
- FIFO:
  - Pop occurs when word_valid && word_ready.
  - Push when not full: always accepted.
  - Push when full with a pop in the same cycle: both occur, no overflow.
  - Push when full without a pop: the new word is dropped and overflow is set.
  - Set has priority over clear_overflow in the same cycle.
  - Wrap-around: read and write pointers are log2(FIFO_DEPTH) bits; an occupancy counter (0 … FIFO_DEPTH) decides full/empty.
- enable low:
  - Partial words are discarded (counters and shift registers cleared on the next edge).
  - FIFO contents are kept, and the consumer can still drain them.
  - Re-enabling starts from div_cnt = 0 with fresh words.

## Timing
- enable sampled high at edge E: cycle E+1 has running = 1, div_cnt = 0, pdm_clk_o = 1.
- Bit n of channel 0 is sampled in cycle E+1 + n·CLK_DIV + CLK_DIV/2 − 1.
- Bit n of channel 1 is sampled half a PDM period later.
- The sampled bit equals data_in from 2 cycles earlier (synchroniser latency).
- Word latency: word_valid = 1 in the cycle after the last-bit sample cycle, with word_data/word_chan valid in that same cycle.
- Pop at edge P: the next entry (or empty) is visible from cycle P+1, i.e. back-to-back pops are possible.
- enable falling at edge D: pdm_clk_o = 0 from cycle D+1; no pushes from cycle D+1 onward.

## Test plan
- Mono, CLK_DIV = 8, WIDTH = 16:
  - Stimulus: enable at edge 0, drive bits of 0xA5C3 MSB-first.
  - Required: word_valid rises in cycle 125 with word_data = 0xA5C3, word_chan = 0; pdm_clk_o has period 8 with 4 cycles high.
- STEREO = 1:
  - Stimulus: channel 0 slots carry 0x1234, channel 1 slots carry 0xFEDC.
  - Required: FIFO outputs 0x1234/chan 0, then 0xFEDC/chan 1, with word_ready held high.
- FIFO_DEPTH = 4, word_ready = 0:
  - Stimulus: 5 words captured.
  - Required: first 4 words retained in order, overflow = 1, 5th word absent.
  - Then clear_overflow for 1 cycle: overflow = 0 and stays 0.
- Full FIFO with a push and a pop on the same edge:
  - Required: occupancy stays 4, overflow stays 0, head advances by one word.
- enable dropped after 7 bits:
  - Required: no word pushed, pdm_clk_o = 0 the next cycle.
  - Re-enable and send 0x00FF: output is 0x00FF, not polluted by the stale bits.
- reset_n asserted mid-word with 2 words queued:
  - Required: all outputs go immediately to their reset values, FIFO empty.
  - After release with enable high: the first word is correct.
